multi_countdown_timer: RTL and testbench
========================================

// Module: multi_countdown_timer
// PURPOSE
//  NCH-channel, WIDTH-bit countdown timer bank with shared tick prescaler, per-channel
//  pause and one-shot/auto-reload mode. Supplies phase durations (green/amber/red,
//  pedestrian walk) to the traffic-light controller FSMs. Each channel is one timer
//  with its own zero flag and a single-cycle expiry pulse.
// PARAMETERS
//  WIDTH     16  counter and load width in bits
//  NCH       4   number of independent channels
//  PRESCALE  1   clk cycles per count tick (1 = decrement every enabled clk)
// PORTS
//  clk        in   1          system clock
//  arstN      in   1          asynchronous reset, active-low
//  tick_en    in   1          global enable of the prescaler; low freezes all channels
//  set        in   NCH        per-channel load strobe
//  load       in   NCH*WIDTH  load values; channel i uses load[i*WIDTH +: WIDTH]
//  reload_mode in  NCH        1 = auto-reload on expiry, 0 = one-shot; sampled on set
//  pause      in   NCH        per-channel hold; count frozen while high
//  count      out  NCH*WIDTH  current count per channel
//  flag_0     out  NCH        1 while channel count == 0 (combinational from count)
//  expired    out  NCH        1-cycle pulse when channel reaches expiry (registered)
// BEHAVIOUR
//  Reset (arstN low, async): all counts 0, reload regs 0, mode regs 0, prescaler 0,
//   expired 0; flag_0 therefore all 1.
//  Prescaler: counter 0..PRESCALE-1 advances only when tick_en=1; tick asserted on the
//   cycle the counter is PRESCALE-1 (wraps to 0). PRESCALE=1 => tick = tick_en. tick_en
//   low holds the prescaler value. Prescaler is shared; never reset by set.
//  Per channel i, priority high to low, at posedge clk:
//   1. set[i]: count <= load_i, reload_reg <= load_i, mode_reg <= reload_mode[i];
//      expired[i] <= 0. set wins over pause, tick and expiry in the same cycle.
//   2. pause[i] or !tick: count holds; expired[i] <= 0.
//   3. tick and count==1: expiry event. expired[i] <= 1. count <= reload_reg if
//      mode_reg=1, else 0.
//   4. tick and count>1: count <= count-1; expired[i] <= 0.
//   5. tick and count==0: hold at 0 (no wrap, no pulse).
//  Latency: load value visible on count 1 cycle after set; expired pulses in the cycle
//   after the tick that consumed count==1, concurrent with count showing 0/reload.
//  Loading 0: flag_0 stays 1, expired never pulses, even in reload mode.
//  Reload mode with reload_reg==1: expires on every tick (pulse every PRESCALE clks).
//  Load value L (>0), one-shot: exactly L ticks from set to expired pulse.
//  Arithmetic: unsigned WIDTH-bit; all-ones load is legal (2^WIDTH-1 ticks).
//  Channels fully independent; simultaneous events on different channels all take effect.
//  Reset mid-countdown aborts immediately; no expiry pulse emitted by reset.
// TESTING
//  1 Reset: arstN low mid-count -> count all 0, flag_0 all 1, expired all 0 at once.
//  2 One-shot, PRESCALE=1: set ch0 load=5, tick_en=1 -> count 5,4,3,2,1,0; expired[0]
//    high exactly 1 cycle, aligned with count=0; stays 0 afterwards, no further pulse.
//  3 Auto-reload: ch1 load=3 reload_mode=1 -> count 3,2,1,3,2,1,3...; expired[1]
//    every 3rd tick with count=3 on the pulse cycle; load=0 reload -> never pulses.
//  4 Pause/tick_en: ch2 load=4, pause[2] high 3 cycles after 1 tick -> holds 3; tick_en
//    low freezes all channels and the prescaler; resume continues with no lost/extra tick.
//  5 Collision: set[0] on same cycle as count==1 tick -> new load taken, expired[0]=0;
//    set with load=0xFFFF -> counts down 65535 ticks without wrap.
//  6 PRESCALE=10, NCH=4: all channels loaded with different values -> each decrements
//    once per 10 enabled clks; expiries independent and correctly timed.

Source files
------------

// File: rtl/multi_countdown_timer.sv
// Bank of NCH independent WIDTH-bit countdown timers sharing one tick prescaler.
// Each channel has pause, one-shot/auto-reload mode, a zero flag and a registered expiry pulse.
module multi_countdown_timer #(
    parameter int WIDTH    = 16,
    parameter int NCH      = 4,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 arstN,
    input  logic                 tick_en,
    input  logic [NCH-1:0]       set,
    input  logic [NCH*WIDTH-1:0] load,
    input  logic [NCH-1:0]       reload_mode,
    input  logic [NCH-1:0]       pause,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       flag_0,
    output logic [NCH-1:0]       expired
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;

    logic [WIDTH-1:0] count_q  [NCH];
    logic [WIDTH-1:0] count_d  [NCH];
    logic [WIDTH-1:0] reload_q [NCH];
    logic [WIDTH-1:0] reload_d [NCH];
    logic [NCH-1:0]   mode_q, mode_d;
    logic [NCH-1:0]   expired_q, expired_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (tick_en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Per-channel priority: set, then hold (pause / no tick), then expiry, then decrement.
    always_comb begin
        mode_d    = mode_q;
        expired_d = '0;
        for (int i = 0; i < NCH; i++) begin
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            if (set[i]) begin
                count_d[i]  = load[i*WIDTH +: WIDTH];
                reload_d[i] = load[i*WIDTH +: WIDTH];
                mode_d[i]   = reload_mode[i];
            end else if (tick && !pause[i]) begin
                if (count_q[i] == WIDTH'(1)) begin
                    expired_d[i] = 1'b1;
                    count_d[i]   = mode_q[i] ? reload_q[i] : '0;
                end else if (count_q[i] != '0) begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all channels see pre-edge values.
    always_ff @(posedge clk or negedge arstN) begin
        if (!arstN) begin
            presc_q   <= '0;
            mode_q    <= '0;
            expired_q <= '0;
            // NOTE: the per-channel arrays are plain flops, not RAM, so they are reset explicitly.
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign count[g*WIDTH +: WIDTH] = count_q[g];
        assign flag_0[g]               = (count_q[g] == '0);
    end

    assign expired = expired_q;

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Scoreboard bench: two timer banks (PRESCALE 1 and 10) share stimulus; a tick-level model
// predicts every cycle's outputs into queues that an independent monitor drains and compares.
module tb_multi_countdown_timer;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct packed {
        logic [N*W-1:0] count;
        logic [N-1:0]   expired;
    } exp_t;

    logic           clk = 1'b0;
    logic           arstN;
    logic           tick_en;
    logic [N-1:0]   set;
    logic [N*W-1:0] load;
    logic [N-1:0]   reload_mode;
    logic [N-1:0]   pause;

    logic [N*W-1:0] count1, count10;
    logic [N-1:0]   flag1, flag10, exp1, exp10;

    exp_t q1[$];
    exp_t q10[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 -> PRESCALE 1 bank, index 1 -> PRESCALE 10 bank
    int unsigned m_cnt  [2][N];
    int unsigned m_rl   [2][N];
    bit          m_md   [2][N];
    int unsigned m_presc[2];

    multi_countdown_timer #(.WIDTH(W), .NCH(N), .PRESCALE(1)) dut1 (
        .clk(clk), .arstN(arstN), .tick_en(tick_en), .set(set), .load(load),
        .reload_mode(reload_mode), .pause(pause),
        .count(count1), .flag_0(flag1), .expired(exp1)
    );

    multi_countdown_timer #(.WIDTH(W), .NCH(N), .PRESCALE(10)) dut10 (
        .clk(clk), .arstN(arstN), .tick_en(tick_en), .set(set), .load(load),
        .reload_mode(reload_mode), .pause(pause),
        .count(count10), .flag_0(flag10), .expired(exp10)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] zero_flags(input logic [N*W-1:0] c);
        logic [N-1:0] f;
        for (int i = 0; i < N; i++) f[i] = (c[i*W +: W] == '0);
        return f;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_presc[d] = 0;
            for (int i = 0; i < N; i++) begin
                m_cnt[d][i] = 0;
                m_rl[d][i]  = 0;
                m_md[d][i]  = 1'b0;
            end
        end
    endtask

    // One clock of the timer rules, expressed per tick rather than per register.
    task automatic model_step(input int d, output exp_t e);
        int unsigned p  = (d == 0) ? 1 : 10;
        bit          tk = tick_en && (m_presc[d] == p - 1);
        if (tick_en) m_presc[d] = (m_presc[d] + 1) % p;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (set[i]) begin
                m_cnt[d][i] = load[i*W +: W];
                m_rl[d][i]  = load[i*W +: W];
                m_md[d][i]  = reload_mode[i];
            end else if (tk && !pause[i]) begin
                if (m_cnt[d][i] == 1) begin
                    e.expired[i] = 1'b1;
                    m_cnt[d][i]  = m_md[d][i] ? m_rl[d][i] : 0;
                end else if (m_cnt[d][i] > 1) begin
                    m_cnt[d][i] = m_cnt[d][i] - 1;
                end
            end
            e.count[i*W +: W] = W'(m_cnt[d][i]);
        end
    endtask

    // Called at a negedge with inputs settled; predicts the next posedge and advances one clock.
    task automatic cycle();
        exp_t e;
        model_step(0, e); q1.push_back(e);
        model_step(1, e); q10.push_back(e);
        @(negedge clk);
        set = '0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic load_ch(input int ch, input logic [W-1:0] val, input logic mode);
        set[ch]             = 1'b1;
        load[ch*W +: W]     = val;
        reload_mode[ch]     = mode;
    endtask

    task automatic reset_now();
        arstN = 1'b0;
        #1;
        check("rst_count1",   count1,  '0);
        check("rst_count10",  count10, '0);
        check("rst_flag1",    flag1,   {N{1'b1}});
        check("rst_flag10",   flag10,  {N{1'b1}});
        check("rst_expired1", exp1,    '0);
        check("rst_expired10", exp10,  '0);
        model_reset();
        @(negedge clk);
        arstN = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("p1_count",   count1, e.count);
                check("p1_expired", exp1,   e.expired);
                check("p1_flag0",   flag1,  zero_flags(e.count));
            end
            if (q10.size() > 0) begin
                e = q10.pop_front();
                check("p10_count",   count10, e.count);
                check("p10_expired", exp10,   e.expired);
                check("p10_flag0",   flag10,  zero_flags(e.count));
            end
        end
    end

    initial begin : stimulus
        arstN       = 1'b0;
        tick_en     = 1'b0;
        set         = '0;
        load        = '0;
        reload_mode = '0;
        pause       = '0;
        model_reset();
        @(negedge clk);
        reset_now();

        // One-shot countdown from 5
        tick_en = 1'b1;
        load_ch(0, 16'd5, 1'b0);
        run(10);

        // Auto-reload period 3, then reload with 0 never pulses
        load_ch(1, 16'd3, 1'b1);
        run(12);
        load_ch(1, 16'd0, 1'b1);
        run(6);

        // Pause one channel, then freeze everything with tick_en low
        load_ch(2, 16'd4, 1'b0);
        run(2);
        pause[2] = 1'b1;
        run(3);
        pause[2] = 1'b0;
        tick_en  = 1'b0;
        run(3);
        tick_en  = 1'b1;
        run(6);

        // set collides with the tick that would consume count==1
        load_ch(0, 16'd2, 1'b0);
        run(2);
        load_ch(0, 16'd7, 1'b0);
        run(10);

        // All channels loaded with distinct values; exercises the prescaled bank
        for (int i = 0; i < N; i++) load_ch(i, W'(3 + 2 * i), i[0]);
        run(120);

        // Randomized traffic with a mid-run asynchronous reset
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) reset_now();
            tick_en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                pause[i] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 15) == 0)
                    load_ch(i, W'($urandom_range(0, 25)), 1'($urandom_range(0, 1)));
            end
            cycle();
        end

        // Full-range countdown with no wrap
        tick_en = 1'b1;
        pause   = '0;
        load_ch(3, 16'hFFFF, 1'b0);
        run(65540);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(q1.size() + q10.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
